// File: rtl/swo_manch_rx.sv
// Manchester SWO receiver: DDR-sampled pin, per-frame bit-rate measurement, LSB-first bytes into a valid/ready FIFO.
// Define SWO_MANCH_RX_GLITCH_FILTER_EN to add a 3-sample majority filter (one extra clk of latency).
module swo_manch_rx #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MIN_HBLEN  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             swo_a,
  input  logic             swo_b,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] halfbit_len,
  output logic             in_frame,
  output logic             err_short,
  output logic             err_coding,
  output logic             err_overrun,
  input  logic             err_clr
);

  localparam int unsigned      AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W+1:0] MINH     = (CNT_W+2)'(MIN_HBLEN);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_MID, S_BOUND} state_t;

  typedef struct packed {
    state_t           st;
    logic             lvl;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h;
    logic [2:0]       idx;
    logic [7:0]       sh;
  } dec_t;

  // One sample of the decoder; called twice per clk so both samples of a pair are honoured in order.
  function automatic dec_t step(input dec_t s, input logic smp,
                                output logic push, output logic e_short, output logic e_code);
    dec_t             n;
    logic             edge_s;
    logic [CNT_W+1:0] iv, ivn, t3, t5;
    n       = s;
    push    = 1'b0;
    e_short = 1'b0;
    e_code  = 1'b0;
    edge_s  = smp ^ s.lvl;
    n.lvl   = smp;
    n.cnt   = edge_s ? CNT_W'(1) : ((s.cnt == '1) ? s.cnt : s.cnt + CNT_W'(1));
    iv      = {2'b00, s.cnt};
    ivn     = {2'b00, n.cnt};
    t3      = {2'b00, s.h} + {3'b000, s.h[CNT_W-1:1]};
    t5      = {1'b0, s.h, 1'b0} + {3'b000, s.h[CNT_W-1:1]};
    case (s.st)
      S_IDLE: begin
        if (edge_s && smp) n.st = S_MEASURE;
      end
      S_MEASURE: begin
        if (edge_s) begin
          if (iv < MINH) begin
            e_short = 1'b1;
            n.st    = S_IDLE;
          end else begin
            n.h   = s.cnt;
            n.idx = '0;
            n.st  = S_MID;
          end
        end
      end
      S_MID: begin
        if (edge_s) begin
          if (iv < t3) begin
            n.st = S_BOUND;
          end else if (iv <= t5) begin
            n.sh  = {s.lvl, s.sh[7:1]};
            n.idx = s.idx + 3'd1;
            push  = (s.idx == 3'd7);
          end else begin
            e_code = (s.idx != '0);
            n.idx  = '0;
            n.st   = S_IDLE;
          end
        end else if (ivn > t5) begin
          e_code = (s.idx != '0);
          n.idx  = '0;
          n.st   = S_IDLE;
        end
      end
      S_BOUND: begin
        if (edge_s) begin
          if (iv < t3) begin
            n.sh  = {s.lvl, s.sh[7:1]};
            n.idx = s.idx + 3'd1;
            push  = (s.idx == 3'd7);
            n.st  = S_MID;
          end else begin
            e_code = 1'b1;
            n.idx  = '0;
            n.st   = S_IDLE;
          end
        end else if (ivn > t5) begin
          e_code = (s.idx != '0);
          n.idx  = '0;
          n.st   = S_IDLE;
        end
      end
      default: n.st = S_IDLE;
    endcase
    return n;
  endfunction

  logic w_d0, w_d1;

`ifdef SWO_MANCH_RX_GLITCH_FILTER_EN
  logic r_ga, r_gb, r_gpp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ga  <= 1'b0;
      r_gb  <= 1'b0;
      r_gpp <= 1'b0;
    end else begin
      r_ga  <= swo_a;
      r_gb  <= swo_b;
      r_gpp <= r_gb;
    end
  end

  // Each delayed sample is voted against its immediate neighbours in stream order.
  assign w_d0 = (r_gpp & r_ga) | (r_gpp & r_gb) | (r_ga & r_gb);
  assign w_d1 = (r_ga & r_gb) | (r_ga & swo_a) | (r_gb & swo_a);
`else
  assign w_d0 = swo_a;
  assign w_d1 = swo_b;
`endif

  dec_t       r_dec, w_n1, w_n2, w_next;
  logic       w_p1, w_p2, w_es1, w_es2, w_ec1, w_ec2;
  logic       w_push, w_set_short, w_set_code;
  logic [7:0] w_pdata;

  always_comb begin
    w_p1  = 1'b0;
    w_p2  = 1'b0;
    w_es1 = 1'b0;
    w_es2 = 1'b0;
    w_ec1 = 1'b0;
    w_ec2 = 1'b0;
    w_n1  = step(r_dec, w_d0, w_p1, w_es1, w_ec1);
    w_n2  = step(w_n1, w_d1, w_p2, w_es2, w_ec2);
    w_next      = w_n2;
    w_push      = w_p1 | w_p2;
    w_pdata     = w_p1 ? w_n1.sh : w_n2.sh;
    w_set_short = w_es1 | w_es2;
    w_set_code  = w_ec1 | w_ec2;
    if (!enable) begin
      w_next      = r_dec;
      w_next.st   = S_IDLE;
      w_next.idx  = '0;
      w_next.lvl  = w_d1;
      w_push      = 1'b0;
      w_set_short = 1'b0;
      w_set_code  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec <= '{st: S_IDLE, lvl: 1'b0, cnt: '0, h: '0, idx: '0, sh: '0};
    end else begin
      r_dec <= w_next;
    end
  end

  assign in_frame    = (r_dec.st == S_MID) || (r_dec.st == S_BOUND);
  assign halfbit_len = r_dec.h;

  logic          r_push;
  logic [7:0]    r_pdata;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          w_full, w_pop, w_wr, w_drop;

  assign w_full    = (r_count == FULL_CNT);
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd];
  assign w_pop     = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr      = r_push && (!w_full || w_pop);
  assign w_drop    = r_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_push  <= 1'b0;
      r_pdata <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_push  <= w_push;
      r_pdata <= w_pdata;
      if (w_wr) begin
        r_mem[r_wr] <= r_pdata;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  logic r_err_short, r_err_coding, r_err_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_short   <= 1'b0;
      r_err_coding  <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_short   <= (r_err_short & ~err_clr) | w_set_short;
      r_err_coding  <= (r_err_coding & ~err_clr) | w_set_code;
      r_err_overrun <= (r_err_overrun & ~err_clr) | w_drop;
    end
  end

  assign err_short   = r_err_short;
  assign err_coding  = r_err_coding;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_swo_manch_rx.sv
// Directed bench for swo_manch_rx: builds sample streams, scoreboards received bytes, checks flags.
module tb_swo_manch_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        swo_a = 1'b0;
  logic        swo_b = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] halfbit_len;
  logic        in_frame;
  logic        err_short, err_coding, err_overrun;
  logic        err_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic       sq[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

`ifdef SWO_MANCH_RX_GLITCH_FILTER_EN
  localparam int LAT_SMP = 2;
`else
  localparam int LAT_SMP = 0;
`endif

  swo_manch_rx #(.CNT_W(16), .FIFO_DEPTH(4), .MIN_HBLEN(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .swo_a(swo_a), .swo_b(swo_b),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halfbit_len(halfbit_len), .in_frame(in_frame),
    .err_short(err_short), .err_coding(err_coding), .err_overrun(err_overrun),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_lvl(input logic v, input int n);
    for (int i = 0; i < n; i++) sq.push_back(v);
  endtask

  task automatic add_bits(input logic [15:0] d, input int nb, input int h);
    add_lvl(1'b1, h);
    add_lvl(1'b0, h);
    for (int i = 0; i < nb; i++) begin
      if (d[i]) begin add_lvl(1'b1, h); add_lvl(1'b0, h); end
      else      begin add_lvl(1'b0, h); add_lvl(1'b1, h); end
    end
  endtask

  task automatic play();
    if (sq.size() % 2 != 0) sq.push_back(1'b0);
    while (sq.size() > 0) begin
      swo_a = sq.pop_front();
      swo_b = sq.pop_front();
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL rx_unexpected: observed %02h expected none", out_data);
      end else begin
        exp_b = exp_q.pop_front();
        assert (out_data === exp_b) else begin
          n_fail++;
          $error("FAIL rx_byte: observed %02h expected %02h", out_data, exp_b);
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_hblen", 32'(halfbit_len), 32'd0);
    chk("rst_inframe", 32'(in_frame), 32'd0);
    chk("rst_errs", 32'({err_short, err_coding, err_overrun}), 32'd0);
    wait_clk(2);
    @(negedge clk) rst_n = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;

    // H=8, 0xA5, in_frame boundary
    out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    add_bits(16'h00A5, 8, 8);
    play();
    chk("t1_inframe_hi", 32'(in_frame), 32'd1);
    add_lvl(1'b0, 14 + LAT_SMP);
    play();
    chk("t1_inframe_lo", 32'(in_frame), 32'd0);
    add_lvl(1'b0, 16);
    play();
    wait_drain();
    chk("t1_hblen", 32'(halfbit_len), 32'd8);
    chk("t1_errs", 32'({err_short, err_coding, err_overrun}), 32'd0);

    // odd H=5, three bytes
    exp_q.push_back(8'h00); add_bits(16'h0000, 8, 5); add_lvl(1'b0, 20);
    exp_q.push_back(8'hFF); add_bits(16'h00FF, 8, 5); add_lvl(1'b0, 20);
    exp_q.push_back(8'h3C); add_bits(16'h003C, 8, 5); add_lvl(1'b0, 20);
    play();
    wait_drain();
    chk("t2_hblen", 32'(halfbit_len), 32'd5);
    chk("t2_errs", 32'({err_short, err_coding, err_overrun}), 32'd0);

    // overrun with consumer stalled
    out_ready = 1'b0;
    for (int b = 1; b <= 6; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      add_bits(16'(b), 8, 8);
      add_lvl(1'b0, 32);
    end
    play();
    wait_clk(4);
    chk("t3_overrun", 32'(err_overrun), 32'd1);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_head", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    wait_drain();
    wait_clk(2);
    chk("t3_empty", 32'(out_valid), 32'd0);
    pulse_clr();
    chk("t3_clr", 32'(err_overrun), 32'd0);

    // short start bit, then valid frame at H=6
    add_lvl(1'b0, 3); add_lvl(1'b1, 1); add_lvl(1'b0, 10);
    play();
    wait_clk(2);
    chk("t4_short", 32'(err_short), 32'd1);
    chk("t4_inframe", 32'(in_frame), 32'd0);
    exp_q.push_back(8'h3C);
    add_bits(16'h003C, 8, 6);
    add_lvl(1'b0, 24);
    play();
    wait_drain();
    chk("t4_hblen", 32'(halfbit_len), 32'd6);
    chk("t4_sticky", 32'(err_short), 32'd1);
    pulse_clr();
    chk("t4_clr", 32'(err_short), 32'd0);

    // 12-bit frame: first byte kept, remainder dropped with error
    exp_q.push_back(8'h5C);
    add_bits(16'h035C, 12, 8);
    add_lvl(1'b0, 32);
    play();
    wait_drain();
    wait_clk(4);
    chk("t5_coding_partial", 32'(err_coding), 32'd1);
    pulse_clr();
    chk("t5_clr", 32'(err_coding), 32'd0);
    // two bits recorded then a 3H high stretch
    add_bits(16'h0003, 2, 8);
    add_lvl(1'b1, 24); add_lvl(1'b0, 32);
    play();
    wait_clk(4);
    chk("t5_coding_3h", 32'(err_coding), 32'd1);
    chk("t5_novalid", 32'(out_valid), 32'd0);
    pulse_clr();
    // 2H interval seen from BOUND
    add_lvl(1'b1, 8); add_lvl(1'b0, 8); add_lvl(1'b1, 16); add_lvl(1'b0, 32);
    play();
    wait_clk(2);
    chk("t5_coding_bound", 32'(err_coding), 32'd1);
    pulse_clr();

    // single-sample low pulse in the high half of bit0 of 0x5A
    add_bits(16'h005A, 8, 8);
    sq[28] = 1'b0;
    add_lvl(1'b0, 32);
`ifdef SWO_MANCH_RX_GLITCH_FILTER_EN
    exp_q.push_back(8'h5A);
    play();
    wait_drain();
    chk("t6_coding", 32'(err_coding), 32'd0);
`else
    play();
    wait_clk(4);
    chk("t6_coding", 32'(err_coding), 32'd1);
    chk("t6_novalid", 32'(out_valid), 32'd0);
`endif
    chk("t6_short", 32'(err_short), 32'd0);
    pulse_clr();

    // enable dropped mid-frame
    add_bits(16'h000F, 4, 8);
    play();
    chk("t7_inframe_hi", 32'(in_frame), 32'd1);
    enable = 1'b0;
    wait_clk(1 + LAT_SMP / 2);
    chk("t7_inframe_lo", 32'(in_frame), 32'd0);
    add_lvl(1'b0, 32);
    play();
    enable = 1'b1;
    wait_clk(8);
    chk("t7_errs", 32'({err_short, err_coding, err_overrun}), 32'd0);
    chk("t7_novalid", 32'(out_valid), 32'd0);

    // reset mid-frame
    add_bits(16'h00F0, 4, 8);
    play();
    chk("t8_inframe_hi", 32'(in_frame), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("t8_inframe", 32'(in_frame), 32'd0);
    chk("t8_hblen", 32'(halfbit_len), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    add_lvl(1'b0, 32);
    play();
    wait_clk(4);
    chk("t8_novalid", 32'(out_valid), 32'd0);
    chk("t8_errs", 32'({err_short, err_coding, err_overrun}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
